adder_pair_sequencer: RTL and testbench

Sequential front/back-end stage wrapped around the 8-bit `adder_gate` datapath. It accepts a byte stream in which every two bytes form one operand pair (x first, then y). It holds the pair stable on the adder inputs for a programmable settle window, then registers the 9-bit `{carry, out}` result. The result is presented on a valid/ready output port, and the block keeps running pair and carry statistics.

---
 rtl/adder_pair_sequencer.sv | 144 ++++++++++++++
 tb/tb_adder_pair_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pair_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_pair_sequencer                                         |
// | Description : Collects byte pairs (x then y), holds them on an external    |
// |               8-bit adder for a settle window, captures {carry, sum} and   |
// |               presents it on a valid/ready port with pair/carry counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adder_pair_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       add_x,
  output logic [7:0]       add_y,
  input  logic [7:0]       add_out,
  input  logic             add_carry,
  output logic             out_valid,
  output logic [8:0]       out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD_X = 2'd0,
    ST_LOAD_Y = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // Settle counter value on which the adder result is sampled.
  localparam logic [3:0]       c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

  state_t           state_q,      state_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             in_ready_q,   in_ready_d;
  logic [7:0]       add_x_q,      add_x_d;
  logic [7:0]       add_y_q,      add_y_d;
  logic             out_valid_q,  out_valid_d;
  logic [8:0]       out_data_q,   out_data_d;
  logic [CNT_W-1:0] pair_cnt_q,   pair_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q,  carry_cnt_d;

  logic w_in_hs;
  logic w_out_hs;

  assign w_in_hs  = in_valid & in_ready_q;
  assign w_out_hs = out_valid_q & out_ready;

  // Next-state and next-output computation for the pair sequencing FSM.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    add_x_d      = add_x_q;
    add_y_d      = add_y_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    pair_cnt_d   = pair_cnt_q;
    carry_cnt_d  = carry_cnt_q;

    case (state_q)
      ST_LOAD_X: begin
        if (w_in_hs) begin
          add_x_d = in_data;
          state_d = ST_LOAD_Y;
        end
      end
      ST_LOAD_Y: begin
        if (w_in_hs) begin
          add_y_d      = in_data;
          settle_cnt_d = 4'd0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == c_settle_last) begin
          // Carry bit is taken straight from the adder, never recomputed here.
          out_data_d  = {add_carry, add_out};
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (w_out_hs) begin
          out_valid_d = 1'b0;
          pair_cnt_d  = pair_cnt_q + c_cnt_one;
          if (out_data_q[8] && (carry_cnt_q != c_cnt_max)) begin
            carry_cnt_d = carry_cnt_q + c_cnt_one;
          end
          state_d = ST_LOAD_X;
        end
      end
      default: state_d = ST_LOAD_X;
    endcase

    // Registered ready depends only on the upcoming state, so there is no
    // combinational path from in_valid or out_ready to in_ready.
    in_ready_d = (state_d == ST_LOAD_X) || (state_d == ST_LOAD_Y);
  end

  // State and output registers; reset clears everything and parks in LOAD_X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD_X;
      settle_cnt_q <= 4'd0;
      in_ready_q   <= 1'b0;
      add_x_q      <= 8'd0;
      add_y_q      <= 8'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 9'd0;
      pair_cnt_q   <= '0;
      carry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      in_ready_q   <= in_ready_d;
      add_x_q      <= add_x_d;
      add_y_q      <= add_y_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      pair_cnt_q   <= pair_cnt_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pair_cnt  = pair_cnt_q;
  assign carry_cnt = carry_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pair_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder_pair_sequencer                                      |
// | Description : Randomised self-checking bench for adder_pair_sequencer.     |
// |               Two instances: settle window 1 (default) and 4.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adder_pair_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      in_valid;
  logic [1:0][7:0] in_data;
  logic [1:0]      out_ready;
  wire  [1:0]      in_ready;
  wire  [1:0]      out_valid;
  wire  [1:0][7:0] add_x;
  wire  [1:0][7:0] add_y;
  wire  [1:0][7:0] add_out;
  wire  [1:0]      add_carry;
  wire  [1:0][8:0] out_data;
  wire  [1:0][7:0] pair_cnt;
  wire  [1:0][7:0] carry_cnt;

  // Behavioural stand-in for the external adder_gate.
  assign {add_carry[0], add_out[0]} = 9'(add_x[0]) + 9'(add_y[0]);
  assign {add_carry[1], add_out[1]} = 9'(add_x[1]) + 9'(add_y[1]);

  adder_pair_sequencer u_dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .add_x(add_x[0]), .add_y(add_y[0]), .add_out(add_out[0]), .add_carry(add_carry[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .pair_cnt(pair_cnt[0]), .carry_cnt(carry_cnt[0])
  );

  adder_pair_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .add_x(add_x[1]), .add_y(add_y[1]), .add_out(add_out[1]), .add_carry(add_carry[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .pair_cnt(pair_cnt[1]), .carry_cnt(carry_cnt[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  // Reference model state: completed results and carry results per instance.
  int n_pairs [2];
  int n_carry [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int exp_pair_cnt(input int d);
    return n_pairs[d] % 256;
  endfunction

  function automatic int exp_carry_cnt(input int d);
    return (n_carry[d] > 255) ? 255 : n_carry[d];
  endfunction

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_in_ready",  in_ready[d],  0);
      check_eq("rst_add_x",     add_x[d],     0);
      check_eq("rst_add_y",     add_y[d],     0);
      check_eq("rst_out_valid", out_valid[d], 0);
      check_eq("rst_out_data",  out_data[d],  0);
      check_eq("rst_pair_cnt",  pair_cnt[d],  0);
      check_eq("rst_carry_cnt", carry_cnt[d], 0);
    end
  endtask

  // Pulse reset for one cycle (asynchronous assert) and clear the model.
  task automatic do_reset();
    in_valid = 2'b00;
    rst_n    = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_pairs[0] = 0; n_pairs[1] = 0;
    n_carry[0] = 0; n_carry[1] = 0;
    @(posedge clk); #1;
    check_eq("rst_ready_rise_0", in_ready[0], 1);
    check_eq("rst_ready_rise_1", in_ready[1], 1);
  endtask

  // Offer one byte with an optional random idle gap; returns just after the
  // accepting edge.
  task automatic push_byte(input int d, input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid[d] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    n = 0;
    while (!in_ready[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq("in_ready_wait", in_ready[d], 1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  // Full pair transaction with optional output backpressure. When pend is
  // set, a byte is offered during the hold and must not be consumed.
  task automatic run_pair(input int d, input logic [7:0] x, input logic [7:0] y,
                          input int hold, input bit pend, input logic [7:0] pend_b,
                          input int max_gap);
    int       lat;
    int       exp_sum;
    exp_sum = int'(x) + int'(y);

    push_byte(d, x, max_gap);
    check_eq("add_x_load", add_x[d], x);
    out_ready[d] = (hold == 0);
    push_byte(d, y, max_gap);
    check_eq("add_y_load", add_y[d], y);
    check_eq("add_x_keep", add_x[d], x);
    check_eq("in_ready_settle", in_ready[d], 0);

    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq(d == 0 ? "latency_s1" : "latency_s4", lat, settle_of(d));
    check_eq("out_data", out_data[d], exp_sum);

    if (hold > 0) begin
      if (pend) begin
        in_valid[d] = 1'b1;
        in_data[d]  = pend_b;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_eq("hold_valid", out_valid[d], 1);
        check_eq("hold_data",  out_data[d],  exp_sum);
        check_eq("hold_ready", in_ready[d],  0);
        check_eq("hold_add_x", add_x[d],     x);
      end
      out_ready[d] = 1'b1;
    end

    @(posedge clk); #1;
    n_pairs[d]++;
    if (exp_sum > 255) n_carry[d]++;
    check_eq("post_valid", out_valid[d], 0);
    check_eq("post_ready", in_ready[d],  1);
    check_eq("pair_cnt",   pair_cnt[d],  exp_pair_cnt(d));
    check_eq("carry_cnt",  carry_cnt[d], exp_carry_cnt(d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] ry;
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data   = '0;
    out_ready = 2'b00;
    n_pairs[0] = 0; n_pairs[1] = 0;
    n_carry[0] = 0; n_carry[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_reset", in_ready[0], 1);

    // Directed pairs on the default-settle instance.
    run_pair(0, 8'h12, 8'h34, 0, 1'b0, 8'h00, 0);
    run_pair(0, 8'hFF, 8'h01, 0, 1'b0, 8'h00, 1);
    run_pair(0, 8'h80, 8'h80, 0, 1'b0, 8'h00, 1);

    // Backpressure with a byte waiting; it becomes the next x.
    run_pair(0, 8'h21, 8'h43, 5, 1'b1, 8'h77, 0);
    run_pair(0, 8'h77, 8'h10, 0, 1'b0, 8'h00, 0);

    // Reset between x and y discards the partial pair.
    push_byte(0, 8'h55, 0);
    do_reset();
    run_pair(0, 8'h01, 8'h02, 0, 1'b0, 8'h00, 0);
    check_eq("mid_reset_pair_cnt", pair_cnt[0], 1);

    // Random traffic, random backpressure.
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      run_pair(0, rx, ry, int'($urandom_range(0, 3)), 1'b0, 8'h00, 2);
    end

    // Longer settle window with input gaps: 12 random pairs.
    for (int i = 0; i < 12; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      run_pair(1, rx, ry, int'($urandom_range(0, 2)), 1'b0, 8'h00, 3);
    end
    check_eq("s4_pair_cnt_12", pair_cnt[1], 12);

    // Counter limits: wrap of pair_cnt, saturation of carry_cnt.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_pair(0, 8'hFF, 8'hFF, 0, 1'b0, 8'h00, 0);
    end
    check_eq("pair_cnt_wrap",  pair_cnt[0],  0);
    check_eq("carry_cnt_sat",  carry_cnt[0], 255);
    run_pair(0, 8'hFF, 8'hFF, 0, 1'b0, 8'h00, 0);
    check_eq("carry_cnt_stay", carry_cnt[0], 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
